// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and unified-memory port of the fetch/data memory arbiter.
// The arbiter connects through the slave modport; the pipeline plus memory side
// (or a testbench standing in for them) uses the master modport.
interface mem_port_arbiter_if;
  // Fetch stage port
  logic        IReqF;
  logic [31:0] IAddrF;
  logic [31:0] IRdataF;
  logic        IValidF;

  // Memory stage port
  logic        DReqM;
  logic        DWeM;
  logic [31:0] DAddrM;
  logic [31:0] DWdataM;
  logic [31:0] DRdataM;
  logic        DValidM;

  // Access aborted by the watchdog
  logic        BusErr;

  // Single-port memory
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        MemAck;

  modport slave (
    input  IReqF, IAddrF,
    input  DReqM, DWeM, DAddrM, DWdataM,
    input  MemRdata, MemAck,
    output IRdataF, IValidF,
    output DRdataM, DValidM,
    output BusErr,
    output MemReq, MemWe, MemAddr, MemWdata
  );

  modport master (
    output IReqF, IAddrF,
    output DReqM, DWeM, DAddrM, DWdataM,
    output MemRdata, MemAck,
    input  IRdataF, IValidF,
    input  DRdataM, DValidM,
    input  BusErr,
    input  MemReq, MemWe, MemAddr, MemWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data wins arbitration so the pipeline drains, except when
// fetch has been waiting through MAX_D_STREAK consecutive data grants. Every
// access occupies IDLE -> GRANT -> RESP, so one access takes at least three
// cycles. A watchdog ends a grant with BusErr if memory never acknowledges.
// All outputs are registered and clear on reset.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  // The streak counter is kept at least 3 bits wide.
  localparam int STREAK_W = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
  localparam int TMO_W    = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Control state
  state_t              state_q,  state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_q,    tmo_d;

  // Registered outputs
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
  logic              i_valid_q,   i_valid_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              d_valid_q,   d_valid_d;
  logic              bus_err_q,   bus_err_d;

  // Arbitration and completion decisions
  logic fetch_starved;
  logic grant_data;
  logic grant_fetch;
  logic access_done;
  logic access_abort;

  // Saturating increment of the consecutive-data-grant streak.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    if (s >= STREAK_MAX) begin
      return STREAK_MAX;
    end
    return s + STREAK_W'(1);
  endfunction

  // Data normally wins; fetch takes over once it has watched a full streak of data grants.
  always_comb begin
    fetch_starved = bus.IReqF && (streak_q == STREAK_MAX);
    grant_data    = (state_q == IDLE) && bus.DReqM && !fetch_starved;
    grant_fetch   = (state_q == IDLE) && !grant_data && bus.IReqF;
  end

  // A grant ends on MemAck; without one it is aborted on its last allowed cycle, ack winning a tie.
  always_comb begin
    access_done  = ((state_q == GRANT_I) || (state_q == GRANT_D)) && bus.MemAck;
    access_abort = ((state_q == GRANT_I) || (state_q == GRANT_D)) && !bus.MemAck &&
                   (tmo_q == TMO_LAST);
  end

  // Next-state and next-output computation for the IDLE/GRANT/RESP access sequence.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant_data) begin
          state_d     = GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.DWeM;
          mem_addr_d  = bus.DAddrM;
          mem_wdata_d = bus.DWdataM;
          // Only grants that make fetch wait count towards the streak.
          streak_d    = bus.IReqF ? streak_inc(streak_q) : '0;
        end else if (grant_fetch) begin
          state_d     = GRANT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.IAddrF;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        if (access_done || access_abort) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = access_abort;
          if (state_q == GRANT_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = access_abort ? '0 : bus.MemRdata;
          end else begin
            d_valid_d = 1'b1;
            // Stores and aborted loads return zero.
            d_rdata_d = (access_abort || mem_we_q) ? '0 : bus.MemRdata;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      RESP: begin
        // The Valid pulse is on the outputs now; requesters update during this cycle.
        state_d = IDLE;
        tmo_d   = '0;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        tmo_d     = '0;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight without a Valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      i_valid_q   <= i_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.MemReq   = mem_req_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWdata = mem_wdata_q;
  assign bus.IRdataF  = i_rdata_q;
  assign bus.IValidF  = i_valid_q;
  assign bus.DRdataM  = d_rdata_q;
  assign bus.DValidM  = d_valid_q;
  assign bus.BusErr   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// requesters and a randomized memory, compared every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT      = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat;
  bit          rand_lat;
  bit          spur_en;
  bit          fixed_en;
  logic [31:0] fixed_rdata;
  int          lat_cnt;
  bit          acked;

  task automatic mem_drive();
    bus.MemAck   = 1'b0;
    bus.MemRdata = fixed_en ? fixed_rdata : 32'($urandom);
    if (bus.MemReq) begin
      if (!acked) begin
        if (lat_cnt == mem_lat) begin
          bus.MemAck = 1'b1;
          acked      = 1'b1;
        end
        lat_cnt++;
      end
    end else begin
      acked   = 1'b0;
      lat_cnt = 0;
      if (rand_lat) begin
        int r;
        r = $urandom_range(0, 19);
        mem_lat = (r < 14) ? (r % 4) : ((r < 17) ? (TIMEOUT - 1) : 40);
      end
      if (spur_en && $urandom_range(0, 3) == 0) bus.MemAck = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return bus.DValidM;
      1:       return bus.IValidF;
      default: return bus.MemReq;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sig_of(sel) && n < limit);
    check(name, 32'(sig_of(sel)), 32'd1);
  endtask

  // ---------------- transaction-level model ----------------
  // owner: 0 none, 1 fetch, 2 data. An access started at cycle g must end by
  // cycle g+TIMEOUT; the cycle after it ends is a dead response cycle.
  int          cyc = 0;
  int          grant_cyc;
  int          owner;
  int          streak;
  bit          in_resp;
  bit          cur_we;
  logic        e_memreq, e_memwe, e_ivalid, e_dvalid, e_buserr, chk_all;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata, v;

  initial begin
    owner = 0; streak = 0; in_resp = 0; cur_we = 0; grant_cyc = 0;
    e_memreq = 0; e_memwe = 0; e_ivalid = 0; e_dvalid = 0; e_buserr = 0; chk_all = 0;
    e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0; v = 0;
    forever begin
      @(posedge clk);
      cyc++;
      chk_all = 0;
      if (reset) begin
        owner = 0; in_resp = 0; streak = 0; chk_all = 1;
        e_memreq = 0; e_memwe = 0; e_ivalid = 0; e_dvalid = 0; e_buserr = 0;
        e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
      end else begin
        e_ivalid = 0; e_dvalid = 0; e_buserr = 0;
        if (in_resp) begin
          in_resp = 0;
        end else if (owner != 0) begin
          if (bus.MemAck || (cyc - grant_cyc) == TIMEOUT) begin
            v        = bus.MemAck ? bus.MemRdata : 32'h0;
            e_buserr = !bus.MemAck;
            e_memreq = 0;
            in_resp  = 1;
            if (owner == 1) begin
              e_ivalid = 1; e_irdata = v;
            end else begin
              e_dvalid = 1; e_drdata = cur_we ? 32'h0 : v;
            end
            owner = 0;
          end
        end else if (bus.DReqM && !(bus.IReqF && streak >= MAX_D_STREAK)) begin
          owner = 2; grant_cyc = cyc; cur_we = bus.DWeM;
          e_memreq = 1; e_memwe = bus.DWeM; e_addr = bus.DAddrM; e_wdata = bus.DWdataM;
          streak = bus.IReqF ? ((streak < MAX_D_STREAK) ? streak + 1 : MAX_D_STREAK) : 0;
        end else if (bus.IReqF) begin
          owner = 1; grant_cyc = cyc; cur_we = 0;
          e_memreq = 1; e_memwe = 0; e_addr = bus.IAddrF;
          streak = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("MemReq",  32'(bus.MemReq),  32'(e_memreq));
        check("IValidF", 32'(bus.IValidF), 32'(e_ivalid));
        check("DValidM", 32'(bus.DValidM), 32'(e_dvalid));
        check("BusErr",  32'(bus.BusErr),  32'(e_buserr));
        if (e_memreq || chk_all) begin
          check("MemWe",   32'(bus.MemWe), 32'(e_memwe));
          check("MemAddr", bus.MemAddr,    e_addr);
        end
        if ((e_memreq && e_memwe) || chk_all) check("MemWdata", bus.MemWdata, e_wdata);
        if (e_ivalid || chk_all) check("IRdataF", bus.IRdataF, e_irdata);
        if (e_dvalid || chk_all) check("DRdataM", bus.DRdataM, e_drdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, nd, hi;
    bit got_i, done;
    reset = 1'b1;
    bus.IReqF = 0; bus.IAddrF = 0;
    bus.DReqM = 0; bus.DWeM = 0; bus.DAddrM = 0; bus.DWdataM = 0;
    bus.MemAck = 0; bus.MemRdata = 0;
    mem_lat = 0; rand_lat = 0; spur_en = 0; fixed_en = 0; fixed_rdata = 0;
    lat_cnt = 0; acked = 0;
    repeat (3) tick();
    check("reset_memreq", 32'(bus.MemReq), 32'd0);
    check("reset_valids", 32'({bus.IValidF, bus.DValidM, bus.BusErr}), 32'd0);
    reset = 1'b0;
    tick();

    // Spurious ack while idle
    bus.MemAck = 1'b1;
    tick();
    check("spur_valid", 32'({bus.IValidF, bus.DValidM}), 32'd0);
    check("spur_memreq", 32'(bus.MemReq), 32'd0);
    tick();

    // Load only
    fixed_en = 1; fixed_rdata = 32'hDEADBEEF; mem_lat = 1;
    bus.DReqM = 1; bus.DWeM = 0; bus.DAddrM = 32'h100; bus.DWdataM = 32'h0;
    tick();
    check("t1_memreq", 32'(bus.MemReq), 32'd1);
    check("t1_addr", bus.MemAddr, 32'h100);
    check("t1_we", 32'(bus.MemWe), 32'd0);
    wait_sig("t1_dvalid", 0, 10, n);
    check("t1_latency", 32'(n), 32'd2);
    check("t1_rdata", bus.DRdataM, 32'hDEADBEEF);
    check("t1_buserr", 32'(bus.BusErr), 32'd0);
    bus.DReqM = 0;
    tick();
    check("t1_pulse", 32'(bus.DValidM), 32'd0);

    // Fetch and store together: store first
    bus.IReqF = 1; bus.IAddrF = 32'h40;
    bus.DReqM = 1; bus.DWeM = 1; bus.DAddrM = 32'h200; bus.DWdataM = 32'h12345678;
    tick();
    check("t2_we", 32'(bus.MemWe), 32'd1);
    check("t2_addr", bus.MemAddr, 32'h200);
    check("t2_wdata", bus.MemWdata, 32'h12345678);
    wait_sig("t2_dvalid", 0, 10, n);
    check("t2_store_rdata", bus.DRdataM, 32'h0);
    check("t2_no_ivalid", 32'(bus.IValidF), 32'd0);
    bus.DReqM = 0; bus.DWeM = 0;
    wait_sig("t2_fetch_grant", 2, 5, n);
    check("t2_faddr", bus.MemAddr, 32'h40);
    check("t2_fwe", 32'(bus.MemWe), 32'd0);
    wait_sig("t2_ivalid", 1, 10, n);
    check("t2_irdata", bus.IRdataF, 32'hDEADBEEF);
    bus.IReqF = 0;
    tick();

    // Starvation limit
    mem_lat = 0;
    bus.IReqF = 1; bus.IAddrF = 32'h80;
    bus.DReqM = 1; bus.DWeM = 0; bus.DAddrM = 32'h300;
    nd = 0; got_i = 0;
    for (int k = 0; k < 100 && !got_i; k++) begin
      tick();
      if (bus.DValidM) nd++;
      if (bus.IValidF) got_i = 1;
    end
    check("t3_fetch_seen", 32'(got_i), 32'd1);
    check("t3_streak", 32'(nd), 32'd4);
    bus.IReqF = 0;
    wait_sig("t3_data_resumes", 0, 10, n);
    bus.DReqM = 0;
    tick();

    // Timeout, then ack on the last allowed cycle
    fixed_rdata = 32'hCAFEF00D;
    for (int t = 0; t < 2; t++) begin
      mem_lat = (t == 0) ? 99 : TIMEOUT - 1;
      bus.DReqM = 1; bus.DWeM = 0; bus.DAddrM = 32'h400;
      hi = 0; done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
        tick();
        if (bus.MemReq) hi++;
        if (bus.DValidM) done = 1;
      end
      check("t4_done", 32'(done), 32'd1);
      check("t4_memreq_cycles", 32'(hi), 32'd16);
      check("t4_buserr", 32'(bus.BusErr), (t == 0) ? 32'd1 : 32'd0);
      check("t4_rdata", bus.DRdataM, (t == 0) ? 32'h0 : 32'hCAFEF00D);
      bus.DReqM = 0;
      tick();
    end

    // Reset mid-access
    mem_lat = 99;
    bus.IReqF = 1; bus.IAddrF = 32'h500;
    wait_sig("t5_grant", 2, 5, n);
    tick();
    tick();
    reset = 1'b1; bus.IReqF = 0;
    tick();
    check("t5_memreq", 32'(bus.MemReq), 32'd0);
    check("t5_ivalid", 32'(bus.IValidF), 32'd0);
    check("t5_buserr", 32'(bus.BusErr), 32'd0);
    check("t5_addr", bus.MemAddr, 32'h0);
    reset = 1'b0;
    bus.MemAck = 1'b1;
    tick();
    check("t5_late_ack", 32'({bus.IValidF, bus.MemReq}), 32'd0);
    tick();
    check("t5_late_ack2", 32'(bus.IValidF), 32'd0);

    // Randomized traffic
    fixed_en = 0; spur_en = 1; rand_lat = 1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      if (!bus.DReqM || bus.DValidM) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.DReqM = 1; bus.DWeM = 1'($urandom_range(0, 1));
          bus.DAddrM = 32'($urandom); bus.DWdataM = 32'($urandom);
        end else begin
          bus.DReqM = 0;
        end
      end
      if (!bus.IReqF || bus.IValidF) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.IReqF = 1; bus.IAddrF = 32'($urandom);
        end else begin
          bus.IReqF = 0;
        end
      end
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
